// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpr_pkg
// Description : Shared sizes and the write-back request type for the GPR
//               file write-back path (64-bit, 32-entry register file).
// Contents    : REG_W, REG_N, IDX_W, wb_req_t {valid, addr, data}
// Revision    : 1.0 - initial release
// ============================================================================
package gpr_pkg;

    localparam int REG_W = 64;
    localparam int REG_N = 32;
    localparam int IDX_W = 5;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] addr;
        logic [REG_W-1:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/gpr_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : gpr_scoreboard
// Description : Busy bits for in-flight long-latency destinations, the
//               outstanding long-op counter and the issue stall.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               iss_*             - issue-stage instruction (valid/rs1/rs2/rd/long)
//               iss_stall         - combinational stall from registered state
//               lsu_done          - LSU write-back handshake this cycle
//               clr_valid/addr    - LSU write committing to the regfile now
//               out_cnt           - outstanding long-op count
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [IDX_W-1:0] iss_rs1,
    input  logic [IDX_W-1:0] iss_rs2,
    input  logic [IDX_W-1:0] iss_rd,
    input  logic             iss_long,
    output logic             iss_stall,
    input  logic             lsu_done,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] clr_addr,
    output logic [3:0]       out_cnt
);

    logic [REG_N-1:0] r_busy;
    logic [REG_N-1:0] w_busy_nxt;
    logic [3:0]       r_out_cnt;
    logic             w_hazard;
    logic             w_full;
    logic             w_accept_long;
    logic             w_set;
    logic             w_dec;

    // No bypass: stall depends only on registered busy bits and count.
    assign w_hazard      = r_busy[iss_rs1] | r_busy[iss_rs2] | r_busy[iss_rd];
    assign w_full        = (r_out_cnt == 4'(MAX_OUT));
    assign iss_stall     = iss_valid & (w_hazard | (iss_long & w_full));
    assign w_accept_long = iss_valid & iss_long & ~iss_stall;
    assign w_set         = w_accept_long & (iss_rd != '0);
    // A handshake with nothing outstanding is a protocol error; saturate at 0.
    assign w_dec         = lsu_done & (r_out_cnt != 4'd0);

    always_comb begin
        w_busy_nxt = r_busy;
        if (clr_valid) begin
            w_busy_nxt[clr_addr] = 1'b0;
        end
        // Set is applied after clear so it takes priority on a collision.
        if (w_set) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_out_cnt <= 4'd0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept_long && !w_dec) begin
                r_out_cnt <= r_out_cnt + 4'd1;
            end else if (w_dec && !w_accept_long) begin
                r_out_cnt <= r_out_cnt - 4'd1;
            end
        end
    end

    assign out_cnt = r_out_cnt;

endmodule
`default_nettype wire

// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_arbiter
// Description : Shares the GPR file's single write port between the EXU and
//               LSU write-back buses through a registered output stage, and
//               stalls issue on hazards against in-flight long-latency ops.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               iss_*                    - issue-stage interface, iss_stall out
//               ex_wb_*                  - EXU write-back valid/ready/addr/data
//               lsu_wb_*                 - LSU write-back valid/ready/addr/data
//               rf_wen/rf_waddr/rf_wdata - registered GPR write port
//               out_cnt                  - outstanding long-op count (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [IDX_W-1:0] iss_rs1,
    input  logic [IDX_W-1:0] iss_rs2,
    input  logic [IDX_W-1:0] iss_rd,
    input  logic             iss_long,
    output logic             iss_stall,
    input  logic             ex_wb_valid,
    output logic             ex_wb_ready,
    input  logic [IDX_W-1:0] ex_wb_addr,
    input  logic [REG_W-1:0] ex_wb_data,
    input  logic             lsu_wb_valid,
    output logic             lsu_wb_ready,
    input  logic [IDX_W-1:0] lsu_wb_addr,
    input  logic [REG_W-1:0] lsu_wb_data,
    output logic             rf_wen,
    output logic [IDX_W-1:0] rf_waddr,
    output logic [REG_W-1:0] rf_wdata,
    output logic [3:0]       out_cnt
);

    localparam int c_STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    wb_req_t                w_ex_req;
    wb_req_t                w_lsu_req;
    wb_req_t                w_sel;
    logic                   w_ex_grant;
    logic                   w_lsu_grant;
    logic                   w_starved;
    logic [c_STARVE_W-1:0]  r_starve;
    logic                   r_rf_wen;
    logic [IDX_W-1:0]       r_rf_waddr;
    logic [REG_W-1:0]       r_rf_wdata;
    logic                   r_pend_lsu;

    assign w_ex_req  = {ex_wb_valid, ex_wb_addr, ex_wb_data};
    assign w_lsu_req = {lsu_wb_valid, lsu_wb_addr, lsu_wb_data};

    // EXU wins by default; the LSU takes the port when the EXU is idle or
    // after losing STARVE_MAX consecutive cycles. No grants during reset.
    assign w_starved   = (r_starve == c_STARVE_W'(STARVE_MAX));
    assign w_lsu_grant = ~rst & w_lsu_req.valid & (~w_ex_req.valid | w_starved);
    assign w_ex_grant  = ~rst & w_ex_req.valid & ~w_lsu_grant;
    assign w_sel       = w_lsu_grant ? w_lsu_req : w_ex_req;

    assign ex_wb_ready  = w_ex_grant;
    assign lsu_wb_ready = w_lsu_grant;

    always_ff @(posedge clk) begin
        if (rst || !lsu_wb_valid || w_lsu_grant) begin
            r_starve <= '0;
        end else if (!w_starved) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Output stage: writes to x0 are accepted but never reach the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_pend_lsu <= 1'b0;
        end else if (w_ex_grant || w_lsu_grant) begin
            r_rf_wen   <= (w_sel.addr != '0);
            r_rf_waddr <= w_sel.addr;
            r_rf_wdata <= w_sel.data;
            r_pend_lsu <= w_lsu_grant;
        end else begin
            r_rf_wen   <= 1'b0;
            r_pend_lsu <= 1'b0;
        end
    end

    assign rf_wen   = r_rf_wen;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

    // The LSU busy bit clears on the edge that ends the rf_wen cycle, so a
    // dependent reading the array combinationally sees the committed value.
    gpr_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_long  (iss_long),
        .iss_stall (iss_stall),
        .lsu_done  (w_lsu_grant),
        .clr_valid (r_rf_wen & r_pend_lsu),
        .clr_addr  (r_rf_waddr),
        .out_cnt   (out_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_wb_arbiter
// Description : Directed self-checking bench for gpr_wb_arbiter
//               (MAX_OUT=4, STARVE_MAX=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_long;
    logic        iss_stall;
    logic        ex_wb_valid, ex_wb_ready;
    logic [4:0]  ex_wb_addr;
    logic [63:0] ex_wb_data;
    logic        lsu_wb_valid, lsu_wb_ready;
    logic [4:0]  lsu_wb_addr;
    logic [63:0] lsu_wb_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [3:0]  out_cnt;

    int tests = 0;
    int fails = 0;

    gpr_wb_arbiter #(.MAX_OUT(4), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_long(iss_long), .iss_stall(iss_stall),
        .ex_wb_valid(ex_wb_valid), .ex_wb_ready(ex_wb_ready),
        .ex_wb_addr(ex_wb_addr), .ex_wb_data(ex_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_long = 0;
        ex_wb_valid = 0; ex_wb_addr = 0; ex_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic lng);
        iss_valid = 1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_long = lng;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        ex_wb_valid = 1; ex_wb_addr = 3; ex_wb_data = 64'h11;
        lsu_wb_valid = 1; lsu_wb_addr = 4; lsu_wb_data = 64'h22;
        issue(1, 2, 3, 1);
        step();
        step();
        tests++; if (ex_wb_ready !== 1'b0) begin fails++; $display("FAIL reset_ex_ready got=%b exp=0", ex_wb_ready); end
        tests++; if (lsu_wb_ready !== 1'b0) begin fails++; $display("FAIL reset_lsu_ready got=%b exp=0", lsu_wb_ready); end
        tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL reset_rf_wen got=%b exp=0", rf_wen); end
        tests++; if (out_cnt !== 4'd0) begin fails++; $display("FAIL reset_out_cnt got=%0d exp=0", out_cnt); end
        tests++; if (rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin fails++; $display("FAIL reset_rf_data got=%0d/%h exp=0/0", rf_waddr, rf_wdata); end
        idle_inputs();
        rst = 0;
        step();
        for (int i = 0; i < 32; i++) begin
            issue(5'(i), 5'(31 - i), 5'(i), 1'b0);
            #1;
            tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL reset_stall_r%0d got=%b exp=0", i, iss_stall); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_long_dep();
        issue(1, 2, 5, 1);
        #1;
        tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL dep_long_issue got=%b exp=0", iss_stall); end
        step();
        tests++; if (out_cnt !== 4'd1) begin fails++; $display("FAIL dep_cnt_inc got=%0d exp=1", out_cnt); end
        issue(5, 0, 6, 0);
        #1;
        tests++; if (iss_stall !== 1'b1) begin fails++; $display("FAIL dep_stall got=%b exp=1", iss_stall); end
        step();
        tests++; if (iss_stall !== 1'b1) begin fails++; $display("FAIL dep_stall_hold got=%b exp=1", iss_stall); end
        // Cycle N: LSU handshake
        lsu_wb_valid = 1; lsu_wb_addr = 5; lsu_wb_data = 64'hDEAD_BEEF;
        #1;
        tests++; if (lsu_wb_ready !== 1'b1) begin fails++; $display("FAIL dep_lsu_ready got=%b exp=1", lsu_wb_ready); end
        tests++; if (iss_stall !== 1'b1) begin fails++; $display("FAIL dep_stall_N got=%b exp=1", iss_stall); end
        step();
        lsu_wb_valid = 0;
        // Cycle N+1: write on the port, still stalled
        tests++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'hDEAD_BEEF) begin
            fails++; $display("FAIL dep_rf_write got=%b/%0d/%h exp=1/5/deadbeef", rf_wen, rf_waddr, rf_wdata); end
        tests++; if (iss_stall !== 1'b1) begin fails++; $display("FAIL dep_stall_N1 got=%b exp=1", iss_stall); end
        tests++; if (out_cnt !== 4'd0) begin fails++; $display("FAIL dep_cnt_dec got=%0d exp=0", out_cnt); end
        step();
        // Cycle N+2: dependent issues
        tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL dep_unstall_N2 got=%b exp=0", iss_stall); end
        tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL dep_rf_wen_off got=%b exp=0", rf_wen); end
        idle_inputs();
        step();
    endtask

    task automatic test_starvation();
        int ex_idx;
        logic exp_lsu;
        logic [4:0] exp_addr;
        logic [63:0] exp_data;
        issue(0, 0, 20, 1);
        step();
        idle_inputs();
        ex_idx = 0;
        for (int c = 1; c <= 5; c++) begin
            ex_wb_valid = 1; ex_wb_addr = 5'(10 + ex_idx); ex_wb_data = 64'(100 + ex_idx);
            lsu_wb_valid = (c <= 4); lsu_wb_addr = 20; lsu_wb_data = 64'hAAAA;
            exp_lsu = (c == 4);
            #1;
            tests++; if (ex_wb_ready !== !exp_lsu || lsu_wb_ready !== exp_lsu) begin
                fails++; $display("FAIL starve_grant_c%0d got ex=%b lsu=%b exp ex=%b lsu=%b", c, ex_wb_ready, lsu_wb_ready, !exp_lsu, exp_lsu); end
            exp_addr = exp_lsu ? 5'd20 : 5'(10 + ex_idx);
            exp_data = exp_lsu ? 64'hAAAA : 64'(100 + ex_idx);
            step();
            tests++; if (rf_wen !== 1'b1 || rf_waddr !== exp_addr || rf_wdata !== exp_data) begin
                fails++; $display("FAIL starve_write_c%0d got=%b/%0d/%h exp=1/%0d/%h", c, rf_wen, rf_waddr, rf_wdata, exp_addr, exp_data); end
            if (!exp_lsu) ex_idx++;
        end
        idle_inputs();
        step();
        tests++; if (out_cnt !== 4'd0) begin fails++; $display("FAIL starve_cnt got=%0d exp=0", out_cnt); end
    endtask

    task automatic test_x0();
        ex_wb_valid = 1; ex_wb_addr = 0; ex_wb_data = 64'h1234;
        #1;
        tests++; if (ex_wb_ready !== 1'b1) begin fails++; $display("FAIL x0_ex_ready got=%b exp=1", ex_wb_ready); end
        step();
        idle_inputs();
        tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL x0_ex_wen got=%b exp=0", rf_wen); end
        issue(0, 0, 0, 1);
        #1;
        tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL x0_long_issue got=%b exp=0", iss_stall); end
        step();
        tests++; if (out_cnt !== 4'd1) begin fails++; $display("FAIL x0_cnt_inc got=%0d exp=1", out_cnt); end
        issue(0, 0, 0, 0);
        #1;
        tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL x0_not_busy got=%b exp=0", iss_stall); end
        idle_inputs();
        lsu_wb_valid = 1; lsu_wb_addr = 0; lsu_wb_data = 64'h55;
        #1;
        tests++; if (lsu_wb_ready !== 1'b1) begin fails++; $display("FAIL x0_lsu_ready got=%b exp=1", lsu_wb_ready); end
        step();
        idle_inputs();
        tests++; if (out_cnt !== 4'd0 || rf_wen !== 1'b0) begin fails++; $display("FAIL x0_lsu_wb got cnt=%0d wen=%b exp cnt=0 wen=0", out_cnt, rf_wen); end
        step();
    endtask

    task automatic test_out_limit();
        for (int r = 1; r <= 4; r++) begin
            issue(0, 0, 5'(r), 1);
            #1;
            tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL lim_issue_r%0d got=%b exp=0", r, iss_stall); end
            step();
        end
        tests++; if (out_cnt !== 4'd4) begin fails++; $display("FAIL lim_cnt4 got=%0d exp=4", out_cnt); end
        issue(9, 10, 8, 1);
        #1;
        tests++; if (iss_stall !== 1'b1) begin fails++; $display("FAIL lim_fifth_stall got=%b exp=1", iss_stall); end
        issue(7, 7, 9, 0);
        #1;
        tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL lim_short_issue got=%b exp=0", iss_stall); end
        step();
        issue(9, 10, 8, 1);
        lsu_wb_valid = 1; lsu_wb_addr = 1; lsu_wb_data = 64'h77;
        #1;
        tests++; if (iss_stall !== 1'b1 || lsu_wb_ready !== 1'b1) begin fails++; $display("FAIL lim_wb_cycle got stall=%b rdy=%b exp 1/1", iss_stall, lsu_wb_ready); end
        step();
        lsu_wb_valid = 0;
        #1;
        tests++; if (iss_stall !== 1'b0 || out_cnt !== 4'd3) begin fails++; $display("FAIL lim_fifth_go got stall=%b cnt=%0d exp 0/3", iss_stall, out_cnt); end
        step();
        idle_inputs();
        tests++; if (out_cnt !== 4'd4) begin fails++; $display("FAIL lim_cnt_after got=%0d exp=4", out_cnt); end
    endtask

    task automatic test_simultaneous();
        rst = 1;
        step();
        rst = 0;
        issue(0, 0, 12, 1);
        step();
        issue(0, 0, 13, 1);
        lsu_wb_valid = 1; lsu_wb_addr = 12; lsu_wb_data = 64'h99;
        #1;
        tests++; if (iss_stall !== 1'b0 || lsu_wb_ready !== 1'b1) begin fails++; $display("FAIL sim_both got stall=%b rdy=%b exp 0/1", iss_stall, lsu_wb_ready); end
        step();
        lsu_wb_valid = 0;
        tests++; if (out_cnt !== 4'd1) begin fails++; $display("FAIL sim_cnt_same got=%0d exp=1", out_cnt); end
        issue(0, 0, 14, 1);
        step();
        tests++; if (out_cnt !== 4'd2) begin fails++; $display("FAIL sim_cnt2 got=%0d exp=2", out_cnt); end
        issue(13, 14, 15, 0);
        #1;
        tests++; if (iss_stall !== 1'b1) begin fails++; $display("FAIL sim_busy_before_rst got=%b exp=1", iss_stall); end
        rst = 1;
        step();
        rst = 0;
        #1;
        tests++; if (out_cnt !== 4'd0) begin fails++; $display("FAIL sim_rst_cnt got=%0d exp=0", out_cnt); end
        tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL sim_rst_busy got=%b exp=0", iss_stall); end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_long_dep();
        test_starvation();
        test_x0();
        test_out_limit();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
